// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store sequencer between the execute stage and a synchronous
// data memory port. It takes one request at a time and rejects misaligned or illegal
// ops without touching memory. Stores get byte enables and lane-replicated write data.
// Accesses that never see Mem_Ack are abandoned after TIMEOUT_CYCLES cycles.
// Loads return the raw word plus the byte offset and op for the extraction stage.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Req_Valid/Req_Ready   request handshake (accepted when both high)
//   Mem_Write, Lw_Sw_OP,  request: store flag, funct3, byte address, store operand
//   Addr, Store_Data
//   Rsp_Valid, Rsp_Data,  one-cycle response with raw word, latched Addr[1:0]/op,
//   Rsp_Byte_Loc,         alignment/illegal-op fault and timeout fault flags
//   Rsp_Lw_Sw_OP,
//   Misalign, Bus_Err
//   Busy                  high whenever not idle
//   Mem_Req, Mem_We,      memory request side, held stable until Mem_Ack
//   Mem_Addr, Mem_Be,
//   Mem_Wdata
//   Mem_Ack, Mem_Rdata    memory completion pulse and read data
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Mem_Write,
    input  logic [2:0]  Lw_Sw_OP,
    input  logic [31:0] Addr,
    input  logic [31:0] Store_Data,
    output logic        Rsp_Valid,
    output logic [31:0] Rsp_Data,
    output logic [1:0]  Rsp_Byte_Loc,
    output logic [2:0]  Rsp_Lw_Sw_OP,
    output logic        Misalign,
    output logic        Bus_Err,
    output logic        Busy,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [3:0]  Mem_Be,
    output logic [31:0] Mem_Wdata,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Rdata
);

    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        fault;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    // State and latch registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            sdata_q <= 32'h0;
            cnt_q   <= 8'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Alignment and legality of the incoming request. Loads allow 000/001/010/100/101;
    // stores allow only 000/001/010.
    always_comb begin
        fault = 1'b0;
        case (Lw_Sw_OP)
            3'b000:  fault = 1'b0;
            3'b001:  fault = Addr[0];
            3'b010:  fault = |Addr[1:0];
            3'b100:  fault = Mem_Write;
            3'b101:  fault = Mem_Write | Addr[0];
            default: fault = 1'b1;
        endcase
    end

    // Next-state and latch updates.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        case (state_q)
            StIdle: begin
                if (Req_Valid) begin
                    we_d    = Mem_Write;
                    op_d    = Lw_Sw_OP;
                    addr_d  = Addr;
                    sdata_d = Store_Data;
                    cnt_d   = 8'h0;
                    rdata_d = 32'h0;
                    berr_d  = 1'b0;
                    mis_d   = fault;
                    state_d = fault ? StResp : StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 8'h1;
                // Ack takes priority over an expiring counter.
                if (Mem_Ack) begin
                    rdata_d = we_q ? 32'h0 : Mem_Rdata;
                    state_d = StResp;
                end else if (cnt_q == LastCnt) begin
                    rdata_d = 32'h0;
                    berr_d  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Byte-lane steering from the latched request. Only legal store ops reach ACCESS,
    // so op_q[1:0] alone selects the width.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = 32'h0;
        if (we_q) begin
            case (op_q[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << addr_q[1:0];
                    lane_wdata = {4{sdata_q[7:0]}};
                end
                2'b01: begin
                    lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{sdata_q[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = sdata_q;
                end
            endcase
        end
    end

    // Outputs. Memory-side buses are forced to zero outside ACCESS so nothing stale
    // leaks onto the port; response flags are qualified by Rsp_Valid.
    always_comb begin
        Req_Ready    = (state_q == StIdle);
        Busy         = (state_q != StIdle);
        Mem_Req      = (state_q == StAccess);
        Mem_We       = Mem_Req & we_q;
        Mem_Addr     = Mem_Req ? {addr_q[31:2], 2'b00} : 32'h0;
        Mem_Be       = Mem_Req ? lane_be : 4'b0000;
        Mem_Wdata    = Mem_Req ? lane_wdata : 32'h0;
        Rsp_Valid    = (state_q == StResp);
        Rsp_Data     = Rsp_Valid ? rdata_q : 32'h0;
        Misalign     = Rsp_Valid & mis_q;
        Bus_Err      = Rsp_Valid & berr_q;
        Rsp_Byte_Loc = addr_q[1:0];
        Rsp_Lw_Sw_OP = op_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int unsigned Timeout = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Mem_Write;
    logic [2:0]  Lw_Sw_OP;
    logic [31:0] Addr;
    logic [31:0] Store_Data;
    logic        Rsp_Valid;
    logic [31:0] Rsp_Data;
    logic [1:0]  Rsp_Byte_Loc;
    logic [2:0]  Rsp_Lw_Sw_OP;
    logic        Misalign;
    logic        Bus_Err;
    logic        Busy;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [3:0]  Mem_Be;
    logic [31:0] Mem_Wdata;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;

    data_mem_ctrl #(.TIMEOUT_CYCLES(Timeout)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req_Valid    (Req_Valid),
        .Req_Ready    (Req_Ready),
        .Mem_Write    (Mem_Write),
        .Lw_Sw_OP     (Lw_Sw_OP),
        .Addr         (Addr),
        .Store_Data   (Store_Data),
        .Rsp_Valid    (Rsp_Valid),
        .Rsp_Data     (Rsp_Data),
        .Rsp_Byte_Loc (Rsp_Byte_Loc),
        .Rsp_Lw_Sw_OP (Rsp_Lw_Sw_OP),
        .Misalign     (Misalign),
        .Bus_Err      (Bus_Err),
        .Busy         (Busy),
        .Mem_Req      (Mem_Req),
        .Mem_We       (Mem_We),
        .Mem_Addr     (Mem_Addr),
        .Mem_Be       (Mem_Be),
        .Mem_Wdata    (Mem_Wdata),
        .Mem_Ack      (Mem_Ack),
        .Mem_Rdata    (Mem_Rdata)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          delay;   // ACCESS cycle carrying Mem_Ack; 0 = never ack
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rsp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  bl;
        logic [2:0]  op;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response is compared against the oldest expected entry.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Rsp_Valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got Rsp_Valid=1 expected none at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_data", Rsp_Data, mon_e.data);
                    chk("rsp_byte_loc", 32'(Rsp_Byte_Loc), 32'(mon_e.bl));
                    chk("rsp_op", 32'(Rsp_Lw_Sw_OP), 32'(mon_e.op));
                    chk("rsp_misalign", 32'(Misalign), 32'(mon_e.mis));
                    chk("rsp_bus_err", 32'(Bus_Err), 32'(mon_e.berr));
                end
            end else begin
                chk("flags_outside_rsp", {30'h0, Misalign, Bus_Err}, 32'h0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!Req_Ready && n < 64) begin
            @(negedge Clk);
            n++;
        end
        chk("req_ready_wait", 32'(Req_Ready), 32'h1);
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [31:0] addr,
                            input logic [2:0] op, input logic mis, input logic berr);
        exp_t e;
        e.data = data;
        e.bl   = addr[1:0];
        e.op   = op;
        e.mis  = mis;
        e.berr = berr;
        sb_q.push_back(e);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wait_ready();
        Req_Valid  = 1'b1;
        Mem_Write  = v.we;
        Lw_Sw_OP   = v.op;
        Addr       = v.addr;
        Store_Data = v.sdata;
        push_exp(v.rsp, v.addr, v.op, v.mis, v.berr);
        @(negedge Clk);
        Req_Valid = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d_fault_no_mem_req", idx), 32'(Mem_Req), 32'h0);
            chk($sformatf("v%0d_fault_rsp_t1", idx), 32'(Rsp_Valid), 32'h1);
        end else begin
            for (int i = 1; i <= int'(Timeout); i++) begin
                chk($sformatf("v%0d_mem_req_c%0d", idx, i), 32'(Mem_Req), 32'h1);
                if (i == 1 || i == v.delay) begin
                    chk($sformatf("v%0d_mem_addr", idx), Mem_Addr, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d_mem_be", idx), 32'(Mem_Be), 32'(v.be));
                    chk($sformatf("v%0d_mem_wdata", idx), Mem_Wdata, v.wdata);
                    chk($sformatf("v%0d_mem_we", idx), 32'(Mem_We), 32'(v.we));
                end
                if (i == v.delay) begin
                    Mem_Ack   = 1'b1;
                    Mem_Rdata = v.rdata;
                end
                @(negedge Clk);
                Mem_Ack   = 1'b0;
                Mem_Rdata = $urandom;
                if (i == v.delay) break;
            end
            chk($sformatf("v%0d_mem_req_dropped", idx), 32'(Mem_Req), 32'h0);
            chk($sformatf("v%0d_rsp_latency", idx), 32'(Rsp_Valid), 32'h1);
        end
        @(negedge Clk);
        chk($sformatf("v%0d_rsp_one_cycle", idx), 32'(Rsp_Valid), 32'h0);
    endtask

    vec_t vecs[13];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "timeout");
    end

    initial begin
        //            we    op      addr          sdata         dly rdata         mis   berr  be       wdata         rsp
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         4, 32'hDEADBEEF, 1'b0, 1'b0, 4'b1111, 32'h0,         32'hDEADBEEF};
        vecs[1]  = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 2, 32'h5555_5555, 1'b0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 3'b100, 32'h0000_0105, 32'h0,         0, 32'h0,         1'b0, 1'b1, 4'b1111, 32'h0,         32'h0};
        vecs[6]  = '{1'b0, 3'b100, 32'h0000_0106, 32'h0,        16, 32'h1122_3344, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h1122_3344};
        vecs[7]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0077, 0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 3'b000, 32'h0000_0200, 32'hFFFF_FF5A, 1, 32'h0,         1'b0, 1'b0, 4'b0001, 32'h5A5A5A5A, 32'h0};
        vecs[9]  = '{1'b1, 3'b001, 32'h0000_0300, 32'hABCD_9876, 3, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0011, 32'h98769876, 32'h0};
        vecs[10] = '{1'b1, 3'b010, 32'h0000_0408, 32'hCAFE_BABE, 2, 32'h0,         1'b0, 1'b0, 4'b1111, 32'hCAFEBABE, 32'h0};
        vecs[11] = '{1'b0, 3'b000, 32'h0000_0007, 32'h0,         3, 32'h0000_0080, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h0000_0080};
        vecs[12] = '{1'b0, 3'b101, 32'h0000_0503, 32'h0,         0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};

        Reset      = 1'b1;
        Req_Valid  = 1'b0;
        Mem_Write  = 1'b0;
        Lw_Sw_OP   = 3'b000;
        Addr       = 32'h0;
        Store_Data = 32'h0;
        Mem_Ack    = 1'b0;
        Mem_Rdata  = 32'h0;
        repeat (2) @(negedge Clk);

        // Reset state.
        chk("rst_req_ready", 32'(Req_Ready), 32'h1);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_mem_req", 32'(Mem_Req), 32'h0);
        chk("rst_mem_we", 32'(Mem_We), 32'h0);
        chk("rst_mem_addr", Mem_Addr, 32'h0);
        chk("rst_mem_be", 32'(Mem_Be), 32'h0);
        chk("rst_mem_wdata", Mem_Wdata, 32'h0);
        chk("rst_rsp_valid", 32'(Rsp_Valid), 32'h0);
        chk("rst_rsp_data", Rsp_Data, 32'h0);
        chk("rst_rsp_tags", {27'h0, Rsp_Byte_Loc, Rsp_Lw_Sw_OP}, 32'h0);
        chk("rst_flags", {30'h0, Misalign, Bus_Err}, 32'h0);
        Reset = 1'b0;

        // A stray ack while idle must not start anything.
        Mem_Ack = 1'b1;
        @(negedge Clk);
        Mem_Ack = 1'b0;
        chk("idle_ack_ignored", {30'h0, Busy, Rsp_Valid}, 32'h0);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Reset during ACCESS: access abandoned, no response, later ack ignored.
        wait_ready();
        Req_Valid = 1'b1;
        Mem_Write = 1'b0;
        Lw_Sw_OP  = 3'b010;
        Addr      = 32'h0000_0043 & 32'hFFFF_FFFC;
        @(negedge Clk);
        Req_Valid = 1'b0;
        repeat (2) @(negedge Clk);
        chk("mid_rst_in_access", 32'(Mem_Req), 32'h1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid_rst_mem_req", 32'(Mem_Req), 32'h0);
        chk("mid_rst_rsp_valid", 32'(Rsp_Valid), 32'h0);
        chk("mid_rst_req_ready", 32'(Req_Ready), 32'h1);
        chk("mid_rst_busy", 32'(Busy), 32'h0);
        Reset   = 1'b0;
        Mem_Ack = 1'b1;
        @(negedge Clk);
        Mem_Ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_ack_no_rsp", {30'h0, Rsp_Valid, Mem_Req}, 32'h0);
            @(negedge Clk);
        end

        // Back-to-back SH then LHU held on the request port throughout.
        wait_ready();
        Req_Valid  = 1'b1;
        Mem_Write  = 1'b1;
        Lw_Sw_OP   = 3'b001;
        Addr       = 32'h0000_0306;
        Store_Data = 32'h0000_1234;
        push_exp(32'h0, 32'h0000_0306, 3'b001, 1'b0, 1'b0);
        @(negedge Clk);
        Mem_Write = 1'b0;
        Lw_Sw_OP  = 3'b101;
        chk("b2b_sh_be", 32'(Mem_Be), 32'h0000_000C);
        chk("b2b_sh_wdata", Mem_Wdata, 32'h1234_1234);
        chk("b2b_sh_we", 32'(Mem_We), 32'h1);
        chk("b2b_busy", 32'(Busy), 32'h1);
        @(negedge Clk);
        chk("b2b_lhu_not_accepted", 32'(Rsp_Lw_Sw_OP), 32'h1);
        Mem_Ack = 1'b1;
        @(negedge Clk);
        Mem_Ack = 1'b0;
        chk("b2b_resp_not_ready", 32'(Req_Ready), 32'h0);
        chk("b2b_resp_op_held", 32'(Rsp_Lw_Sw_OP), 32'h1);
        push_exp(32'hCAFE_F00D, 32'h0000_0306, 3'b101, 1'b0, 1'b0);
        @(negedge Clk);
        chk("b2b_idle_ready", 32'(Req_Ready), 32'h1);
        @(negedge Clk);
        Req_Valid = 1'b0;
        chk("b2b_lhu_mem_req", 32'(Mem_Req), 32'h1);
        chk("b2b_lhu_we", 32'(Mem_We), 32'h0);
        chk("b2b_lhu_be", 32'(Mem_Be), 32'h0000_000F);
        chk("b2b_lhu_op", 32'(Rsp_Lw_Sw_OP), 32'h5);
        chk("b2b_lhu_byte_loc", 32'(Rsp_Byte_Loc), 32'h2);
        Mem_Ack   = 1'b1;
        Mem_Rdata = 32'hCAFE_F00D;
        @(negedge Clk);
        Mem_Ack = 1'b0;
        chk("b2b_lhu_rsp", 32'(Rsp_Valid), 32'h1);
        repeat (2) @(negedge Clk);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
